// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11 single-wire reader: FSM state codes,
// error codes, frame size and the frame checksum rule.
package dht_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START_LOW = 4'd1;
    localparam logic [3:0] ST_WAIT_RESP = 4'd2;
    localparam logic [3:0] ST_RESP_LOW  = 4'd3;
    localparam logic [3:0] ST_RESP_HIGH = 4'd4;
    localparam logic [3:0] ST_BIT_LOW   = 4'd5;
    localparam logic [3:0] ST_BIT_HIGH  = 4'd6;
    localparam logic [3:0] ST_CHECK     = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NORESP  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CHKSUM  = 2'b11;

    localparam int DATA_BITS = 40;

    // Frame layout MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum.
    function automatic logic checksum_ok(input logic [DATA_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

endpackage

// File: rtl/dht_sync_edge.sv
// Two-flop synchronizer for the DHT pad plus edge detection on the
// synchronized level. Resets to 1, the idle pull-up level, so no edge is
// reported coming out of reset.
module dht_sync_edge (
    input  logic slow_clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronizer chain followed by a one-cycle history flop for edges.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire master: issues the host start pulse, follows the sensor
// response, times 40 data bits, verifies the checksum and publishes the
// integer humidity and temperature bytes.
module dht11_reader
    import dht_pkg::*;
#(
    parameter int US_CYCLES      = 1,
    parameter int START_LOW_US   = 18000,
    parameter int TIMEOUT_US     = 200,
    parameter int BIT1_THRESH_US = 40
) (
    input  logic       slow_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       data_valid,
    output logic [7:0] hum_int,
    output logic [7:0] temp_int,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int START_CYC   = START_LOW_US * US_CYCLES;
    localparam int TIMEOUT_CYC = TIMEOUT_US * US_CYCLES;
    localparam int BIT1_CYC    = BIT1_THRESH_US * US_CYCLES;
    localparam int LONGEST     = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
    localparam int CNT_W       = $clog2(LONGEST + 2);
    localparam int IDX_W       = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] START_END = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TO_END    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] BIT1_TH   = CNT_W'(BIT1_CYC);
    // Right after release the synchronizer still shows our own start pulse
    // for two cycles; a low seen then is not the sensor answering.
    localparam logic [CNT_W-1:0] SYNC_BLANK = CNT_W'(2);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);

    logic [3:0]           state;
    logic [3:0]           state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 lvl;
    logic                 rise;
    logic                 fall;
    logic                 timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    dht_sync_edge u_sync (
        .slow_clk (slow_clk),
        .rst_n    (rst_n),
        .din      (dht_in),
        .level    (lvl),
        .rise     (rise),
        .fall     (fall)
    );

    assign timeout = (cnt == TO_END);

    // Next-state selection; a pad edge wins over a timeout in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (start) state_nx = ST_START_LOW;
            ST_START_LOW: if (cnt == START_END) state_nx = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (cnt >= SYNC_BLANK && !lvl) state_nx = ST_RESP_LOW;
                else if (timeout)             state_nx = ST_ERROR;
            end
            ST_RESP_LOW: begin
                if (rise)         state_nx = ST_RESP_HIGH;
                else if (timeout) state_nx = ST_ERROR;
            end
            ST_RESP_HIGH: begin
                if (fall)         state_nx = ST_BIT_LOW;
                else if (timeout) state_nx = ST_ERROR;
            end
            ST_BIT_LOW: begin
                if (rise)         state_nx = ST_BIT_HIGH;
                else if (timeout) state_nx = ST_ERROR;
            end
            ST_BIT_HIGH: begin
                if (fall)         state_nx = (bit_idx == LAST_IDX) ? ST_CHECK : ST_BIT_LOW;
                else if (timeout) state_nx = ST_ERROR;
            end
            ST_CHECK:     state_nx = checksum_ok(shreg) ? ST_IDLE : ST_ERROR;
            ST_ERROR:     state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    // State, phase counter, bit capture, result registers and error code.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            hum_int    <= 8'd0;
            temp_int   <= 8'd0;
            err_code   <= ERR_NONE;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= (state_nx != state) ? '0 : sat_inc(cnt);
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: if (start) err_code <= ERR_NONE;
                ST_WAIT_RESP: if (state_nx == ST_ERROR) err_code <= ERR_NORESP;
                ST_RESP_HIGH: begin
                    if (fall)                        bit_idx  <= '0;
                    else if (state_nx == ST_ERROR)   err_code <= ERR_TIMEOUT;
                end
                ST_RESP_LOW, ST_BIT_LOW: if (state_nx == ST_ERROR) err_code <= ERR_TIMEOUT;
                ST_BIT_HIGH: begin
                    if (fall) begin
                        // cnt trails the synchronized high time by one cycle,
                        // so cnt >= threshold means high time > threshold.
                        shreg   <= {shreg[DATA_BITS-2:0], (cnt >= BIT1_TH)};
                        bit_idx <= bit_idx + 1'b1;
                    end else if (state_nx == ST_ERROR) begin
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_CHECK: begin
                    if (checksum_ok(shreg)) begin
                        hum_int    <= shreg[39:32];
                        temp_int   <= shreg[23:16];
                        data_valid <= 1'b1;
                    end else begin
                        err_code <= ERR_CHKSUM;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decoded from the state register so an asynchronous reset releases the
    // pad and drops busy immediately.
    assign dht_oe = (state == ST_START_LOW);
    assign busy   = (state != ST_IDLE);
    assign error  = (state == ST_ERROR);

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a pulse-level DHT11 sensor model drives the pad,
// a frame-level model predicts the result of each measurement, and a
// monitor compares the DUT outputs against that prediction every cycle.
module tb_dht11_reader;

    localparam int START_US = 100;
    localparam int TO_US    = 200;
    localparam int BIT1_US  = 40;

    logic       slow_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       sen      = 1'b1;
    logic       dht_in;
    logic       dht_oe;
    logic       busy;
    logic       data_valid;
    logic [7:0] hum_int;
    logic [7:0] temp_int;
    logic       error;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_error = 0;

    // Model state: last good reading and the outcome expected for the
    // measurement in flight (0 none, 1 data_valid, 2 error).
    logic [7:0] m_hum = 8'd0;
    logic [7:0] m_temp = 8'd0;
    int         exp_kind = 0;
    logic [1:0] exp_code = 2'b00;
    logic [7:0] exp_hum = 8'd0;
    logic [7:0] exp_temp = 8'd0;

    // Open-drain pad: host drive low wins over the sensor line.
    assign dht_in = dht_oe ? 1'b0 : sen;

    always #5 slow_clk = ~slow_clk;

    dht11_reader #(
        .US_CYCLES      (1),
        .START_LOW_US   (START_US),
        .TIMEOUT_US     (TO_US),
        .BIT1_THRESH_US (BIT1_US)
    ) dut (
        .slow_clk   (slow_clk),
        .rst_n      (rst_n),
        .start      (start),
        .dht_in     (dht_in),
        .dht_oe     (dht_oe),
        .busy       (busy),
        .data_valid (data_valid),
        .hum_int    (hum_int),
        .temp_int   (temp_int),
        .error      (error),
        .err_code   (err_code)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        sen = v;
        repeat (n) @(negedge slow_clk);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge slow_clk) begin
        if (rst_n) begin
            if (data_valid) begin
                n_valid++;
                chk("valid_expected", exp_kind, 1);
                chk("hum_int", int'(hum_int), int'(exp_hum));
                chk("temp_int", int'(temp_int), int'(exp_temp));
                m_hum  = exp_hum;
                m_temp = exp_temp;
                exp_kind = 0;
            end else begin
                chk("hum_hold", int'(hum_int), int'(m_hum));
                chk("temp_hold", int'(temp_int), int'(m_temp));
            end
            if (error) begin
                n_error++;
                chk("error_expected", exp_kind, 2);
                chk("err_code_at_error", int'(err_code), int'(exp_code));
                exp_kind = 0;
            end
            if (!busy) chk("oe_released_idle", int'(dht_oe), 0);
            chk("pulse_exclusive", int'(data_valid & error), 0);
        end
    end

    task automatic pulse_start();
        @(negedge slow_clk);
        start = 1'b1;
        @(negedge slow_clk);
        start = 1'b0;
    endtask

    // One measurement. stall_bit >= 0 holds the pad high from that bit on;
    // with do_reset the DUT is reset while it times that stalled bit.
    task automatic run_meas(input logic [39:0] frame, input int hi0, input int hi1,
                            input int stall_bit, input bit do_reset);
        logic [39:0] dec;
        int hi, sum, n, kind, nv0, ne0;
        logic [1:0] code;
        for (int i = 0; i < 40; i++) begin
            hi = frame[39-i] ? hi1 : hi0;
            dec[39-i] = (hi > BIT1_US);
        end
        sum = (int'(dec[39:32]) + int'(dec[31:24]) + int'(dec[23:16]) + int'(dec[15:8])) % 256;
        if (stall_bit >= 0) begin
            kind = 2; code = 2'b10;
        end else if (sum == int'(dec[7:0])) begin
            kind = 1; code = 2'b00;
        end else begin
            kind = 2; code = 2'b11;
        end
        if (do_reset) kind = 0;
        exp_kind = kind; exp_code = code;
        exp_hum = dec[39:32]; exp_temp = dec[23:16];
        nv0 = n_valid; ne0 = n_error;
        sen = 1'b1;
        pulse_start();
        chk("start_busy", int'(busy), 1);
        chk("start_clears_err", int'(err_code), 0);
        n = 0;
        while (dht_oe === 1'b1 && n < 30000) begin
            n++;
            @(negedge slow_clk);
        end
        chk("start_low_len", n, START_US);
        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            hold(1'b0, 50);
            if (i == stall_bit) break;
            hold(1'b1, frame[39-i] ? hi1 : hi0);
        end
        if (stall_bit < 0) begin
            hold(1'b0, 50);
            sen = 1'b1;
        end else if (do_reset) begin
            hold(1'b1, 10);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy", int'(busy), 0);
            chk("rst_oe", int'(dht_oe), 0);
            chk("rst_hum", int'(hum_int), 0);
            chk("rst_temp", int'(temp_int), 0);
            chk("rst_err_code", int'(err_code), 0);
            chk("rst_valid", int'(data_valid), 0);
            chk("rst_error", int'(error), 0);
            m_hum = 8'd0; m_temp = 8'd0;
            repeat (2) @(negedge slow_clk);
            rst_n = 1'b1;
            repeat (5) @(negedge slow_clk);
            chk("rst_idle", int'(busy), 0);
            chk("rst_no_valid", n_valid, nv0);
            chk("rst_no_error", n_error, ne0);
            return;
        end else begin
            hold(1'b1, 20);
            start = 1'b1;
            @(negedge slow_clk);
            start = 1'b0;
            chk("start_ignored_busy", int'(busy), 1);
            chk("start_ignored_code", int'(err_code), 0);
        end
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge slow_clk);
        end
        chk("done_in_time", int'(busy), 0);
        chk("err_code_final", int'(err_code), int'(code));
        chk("valid_count", n_valid, nv0 + ((kind == 1) ? 1 : 0));
        chk("error_count", n_error, ne0 + ((kind == 2) ? 1 : 0));
        repeat (5) begin
            @(negedge slow_clk);
            chk("no_requeue", int'(busy), 0);
        end
    endtask

    initial begin
        int n, ne0;
        repeat (3) @(negedge slow_clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_oe", int'(dht_oe), 0);
        chk("reset_valid", int'(data_valid), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_hum", int'(hum_int), 0);
        chk("reset_temp", int'(temp_int), 0);
        chk("reset_err_code", int'(err_code), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge slow_clk);
        chk("post_reset_busy", int'(busy), 0);

        run_meas(40'h36_00_19_00_4F, 26, 70, -1, 1'b0);
        chk("lit_hum_54", int'(hum_int), 54);
        chk("lit_temp_25", int'(temp_int), 25);
        chk("lit_err_none", int'(err_code), 0);

        run_meas(40'h36_00_19_00_50, 26, 70, -1, 1'b0);
        chk("lit_chk_code", int'(err_code), 3);
        chk("lit_chk_hum_kept", int'(hum_int), 54);
        chk("lit_chk_temp_kept", int'(temp_int), 25);

        // No sensor: pad only ever pulled up after the start pulse.
        exp_kind = 2; exp_code = 2'b01; ne0 = n_error;
        sen = 1'b1;
        pulse_start();
        n = 0;
        while (dht_oe === 1'b1 && n < 30000) begin
            n++;
            @(negedge slow_clk);
        end
        chk("noresp_start_len", n, START_US);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge slow_clk);
        end
        chk("noresp_window", int'(n >= TO_US && n <= TO_US + 6), 1);
        chk("noresp_code", int'(err_code), 1);
        chk("noresp_error_count", n_error, ne0 + 1);
        chk("noresp_oe", int'(dht_oe), 0);

        run_meas(40'h2A_01_1C_05_4C, 40, 41, -1, 1'b0);
        chk("lit_thresh_hum", int'(hum_int), 42);
        chk("lit_thresh_temp", int'(temp_int), 28);

        // Every high pulse sits at or under the threshold: an all-zero frame.
        run_meas(40'hFF_FF_FF_FF_FC, 26, 40, -1, 1'b0);
        chk("lit_eq_thresh_hum", int'(hum_int), 0);
        chk("lit_eq_thresh_temp", int'(temp_int), 0);

        run_meas(40'h36_00_19_00_4F, 26, 70, 17, 1'b0);
        chk("lit_stall_code", int'(err_code), 2);

        run_meas(40'h36_00_19_00_4F, 26, 70, -1, 1'b0);
        chk("lit_after_stall_hum", int'(hum_int), 54);

        run_meas(40'h36_00_19_00_4F, 26, 70, 10, 1'b1);

        run_meas(40'h5A_03_17_09_7D, 26, 70, -1, 1'b0);
        chk("lit_last_hum", int'(hum_int), 90);
        chk("lit_last_temp", int'(temp_int), 23);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
